// File: rtl/overflow_irq_ctrl.sv
// overflow_irq_ctrl
// Collects per-channel overflow pulses into sticky SR flags, counts overflow
// events per channel with saturating counters, and presents one pending
// channel at a time to a consumer through a round-robin grant FSM.
//
// Ports
//   clk        sole clock, all state updates on posedge
//   rst        synchronous active-high reset
//   en         grant enable, low only blocks new grants
//   ovf_set    per-channel overflow pulse (set input of the flag)
//   ovf_clr    per-channel software clear (reset input of the flag)
//   cnt_clr    clears all event counters
//   irq_valid  registered, high while a channel is granted
//   irq_id     registered, index of the granted channel
//   irq_ack    consumer acknowledge of the presented channel
//   flags      registered sticky overflow flags
//   cnt_sel    counter read select
//   cnt_out    combinational read of the selected counter
module overflow_irq_ctrl #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NCH-1:0]          ovf_set,
  input  logic [NCH-1:0]          ovf_clr,
  input  logic                    cnt_clr,
  output logic                    irq_valid,
  output logic [$clog2(NCH)-1:0]  irq_id,
  input  logic                    irq_ack,
  output logic [NCH-1:0]          flags,
  input  logic [$clog2(NCH)-1:0]  cnt_sel,
  output logic [CW-1:0]           cnt_out
);

  localparam int IW = $clog2(NCH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e          state_q;
  logic            irq_valid_q;
  logic [IW-1:0]   irq_id_q;
  logic [IW-1:0]   ptr_q;
  logic [NCH-1:0]  flags_q;
  logic [NCH-1:0]  flags_d;
  logic [NCH-1:0]  ack_clr_d;
  logic [CW-1:0]   cnt_q [NCH];
  logic [CW-1:0]   cnt_d [NCH];
  logic [IW-1:0]   rr_idx_d [NCH];
  logic [IW-1:0]   pick_id_d;

  // Acknowledge clears only the channel currently presented in GRANT.
  always_comb begin
    ack_clr_d = '0;
    if (state_q == GRANT && irq_ack) begin
      ack_clr_d[irq_id_q] = 1'b1;
    end else begin
      ack_clr_d = '0;
    end
  end

  // SR flag update: a set in the same cycle beats either kind of clear.
  always_comb begin
    flags_d = ovf_set | (flags_q & ~ovf_clr & ~ack_clr_d);
  end

  // Search order: rr_idx_d[k] = (ptr + 1 + k) mod NCH, computed without
  // widening by comparing ptr against the distance to the wrap point.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      if (ptr_q >= IW'(NCH - 1 - k)) begin
        rr_idx_d[k] = ptr_q - IW'(NCH - 1 - k);
      end else begin
        rr_idx_d[k] = ptr_q + IW'(k + 1);
      end
    end
  end

  // Walk the search order backwards so the earliest set candidate wins.
  always_comb begin
    pick_id_d = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      pick_id_d = flags_q[rr_idx_d[k]] ? rr_idx_d[k] : pick_id_d;
    end
  end

  // Saturating event counters; a clear coinciding with an event leaves 1.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      if (cnt_clr) begin
        cnt_d[i] = ovf_set[i] ? CW'(1) : '0;
      end else if (ovf_set[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Counter read port; selects beyond NCH read as zero.
  always_comb begin
    if (int'(cnt_sel) < NCH) begin
      cnt_out = cnt_q[cnt_sel];
    end else begin
      cnt_out = '0;
    end
  end

  // Flag and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Grant FSM with registered irq_valid/irq_id; ptr holds the last acked
  // channel so the next search starts just after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      ptr_q       <= IW'(NCH - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (en && (|flags_q)) begin
            irq_id_q    <= pick_id_d;
            irq_valid_q <= 1'b1;
            state_q     <= GRANT;
          end else begin
            irq_valid_q <= 1'b0;
          end
        end
        GRANT: begin
          if (irq_ack) begin
            ptr_q       <= irq_id_q;
            irq_valid_q <= 1'b0;
            state_q     <= HOLD;
          end else if (ovf_clr[irq_id_q] && !ovf_set[irq_id_q]) begin
            // Software cleared the presented flag: withdraw, keep ptr.
            irq_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            irq_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          irq_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          irq_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_overflow_irq_ctrl.sv
// Scoreboard bench for overflow_irq_ctrl: the stimulus process advances a
// behavioural model and queues the expected post-edge outputs; a monitor
// process pops and compares them after every rising edge.
module tb_overflow_irq_ctrl;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int IW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [NCH-1:0] ovf_set;
  logic [NCH-1:0] ovf_clr;
  logic           cnt_clr;
  logic           irq_valid;
  logic [IW-1:0]  irq_id;
  logic           irq_ack;
  logic [NCH-1:0] flags;
  logic [IW-1:0]  cnt_sel;
  logic [CW-1:0]  cnt_out;

  always #5 clk = ~clk;

  overflow_irq_ctrl #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .ovf_set(ovf_set), .ovf_clr(ovf_clr),
    .cnt_clr(cnt_clr), .irq_valid(irq_valid), .irq_id(irq_id),
    .irq_ack(irq_ack), .flags(flags), .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  typedef struct {
    int v;
    int id;
    int fl;
    int cnt;
  } exp_t;

  exp_t expq[$];
  int   seen[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: mode 0 = waiting, 1 = presenting, 2 = pause cycle.
  bit m_flag[NCH];
  int m_cnt[NCH];
  int m_mode;
  int m_gid;
  int m_ptr;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_seen(input string nm, input int exp[$]);
    chk({nm, "_count"}, seen.size(), exp.size());
    for (int i = 0; i < exp.size() && i < seen.size(); i++) begin
      chk(nm, seen[i], exp[i]);
    end
  endtask

  // One clock cycle of stimulus plus the model's view of the result.
  task automatic step(input logic [NCH-1:0] s, input logic [NCH-1:0] c,
                      input logic a, input logic e, input logic cc,
                      input logic r, input int sel);
    exp_t x;
    int   nmode;
    int   ngid;
    int   nptr;
    int   cand;
    bit   any;
    bit   acked;
    @(negedge clk);
    ovf_set = s; ovf_clr = c; irq_ack = a; en = e; cnt_clr = cc; rst = r;
    cnt_sel = IW'(sel);
    if (r) begin
      for (int i = 0; i < NCH; i++) begin
        m_flag[i] = 1'b0;
        m_cnt[i]  = 0;
      end
      m_mode = 0; m_gid = 0; m_ptr = NCH - 1;
    end else begin
      nmode = m_mode; ngid = m_gid; nptr = m_ptr;
      any = 1'b0;
      for (int i = 0; i < NCH; i++) any |= m_flag[i];
      acked = (m_mode == 1) && a;
      if (m_mode == 0) begin
        if (e && any) begin
          for (int k = NCH; k >= 1; k--) begin
            cand = (m_ptr + k) % NCH;
            if (m_flag[cand]) ngid = cand;
          end
          nmode = 1;
        end
      end else if (m_mode == 1) begin
        if (a) begin
          nptr = m_gid; nmode = 2;
        end else if (c[m_gid] && !s[m_gid]) begin
          nmode = 0;
        end
      end else begin
        nmode = 0;
      end
      for (int i = 0; i < NCH; i++) begin
        m_flag[i] = s[i] | (m_flag[i] & !c[i] & !(acked && m_gid == i));
        if (cc) m_cnt[i] = s[i] ? 1 : 0;
        else if (s[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
      end
      m_mode = nmode; m_gid = ngid; m_ptr = nptr;
    end
    x.v = (m_mode == 1) ? 1 : 0;
    x.id = m_gid;
    x.fl = 0;
    for (int i = 0; i < NCH; i++) x.fl |= (int'(m_flag[i]) << i);
    x.cnt = m_cnt[sel];
    expq.push_back(x);
  endtask

  task automatic idle(input int n, input int sel);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0, sel);
  endtask

  task automatic do_reset();
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    seen.delete();
  endtask

  // Acknowledge every grant immediately until nothing is pending.
  task automatic drain_acks(input int budget, input int sel);
    int left;
    bit any;
    left = budget;
    any = 1'b1;
    while (left > 0 && (any || m_mode != 0)) begin
      step('0, '0, (m_mode == 1), 1'b1, 1'b0, 1'b0, sel);
      any = 1'b0;
      for (int i = 0; i < NCH; i++) any |= m_flag[i];
      left--;
    end
    chk("drain_budget", int'(left > 0), 1);
  endtask

  // Monitor: compare queued expectations after each rising edge.
  initial begin
    exp_t x;
    int   prev_v;
    prev_v = 0;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk("irq_valid", int'(irq_valid), x.v);
        if (x.v != 0) chk("irq_id", int'(irq_id), x.id);
        chk("flags", int'(flags), x.fl);
        chk("cnt_out", int'(cnt_out), x.cnt);
        if (irq_valid === 1'b1 && prev_v == 0) seen.push_back(int'(irq_id));
        prev_v = int'(irq_valid === 1'b1);
      end
    end
  end

  initial begin
    int exp_order[$];
    rst = 1'b1; en = 1'b0; ovf_set = '0; ovf_clr = '0; cnt_clr = 1'b0;
    irq_ack = 1'b0; cnt_sel = '0;
    m_mode = 0; m_gid = 0; m_ptr = NCH - 1;
    for (int i = 0; i < NCH; i++) begin
      m_flag[i] = 1'b0; m_cnt[i] = 0;
    end

    // Single event on channel 2 with ack.
    do_reset();
    step(4'b0100, '0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    idle(1, 2);
    step('0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
    idle(2, 2);
    exp_order = '{2};
    chk_seen("single_order", exp_order);

    // Round robin: all four, then 0 and 3.
    do_reset();
    step(4'b1111, '0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    drain_acks(40, 1);
    step(4'b1001, '0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    drain_acks(40, 3);
    idle(1, 0);
    exp_order = '{0, 1, 2, 3, 0, 3};
    chk_seen("rr_order", exp_order);

    // Set beats ack-clear on channel 1 with 2 and 3 pending.
    do_reset();
    step(4'b1110, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    idle(1, 1);
    step(4'b0010, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1);
    drain_acks(40, 1);
    idle(1, 1);
    #1;
    chk("set_beats_clr_cnt1", int'(cnt_out), 2);
    exp_order = '{1, 2, 3, 1};
    chk_seen("set_beats_clr_order", exp_order);

    // Withdraw grant of channel 2; ptr must stay at reset value.
    do_reset();
    step(4'b0100, '0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    idle(1, 2);
    step('0, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    step(4'b1001, '0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    drain_acks(40, 0);
    idle(1, 0);
    exp_order = '{2, 0, 3};
    chk_seen("withdraw_order", exp_order);

    // Counter saturation and clear-with-set.
    do_reset();
    for (int i = 0; i < 300; i++) step(4'b0001, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    step(4'b0001, '0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    #1;
    chk("sat_255", int'(cnt_out), 255);
    step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    #1;
    chk("clr_with_set", int'(cnt_out), 1);

    // Reset while channel 1 is granted, then lowest set flag wins.
    do_reset();
    step(4'b1010, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    idle(1, 1);
    step('0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    step(4'b1100, '0, 1'b0, 1'b1, 1'b0, 1'b0, 3);
    idle(2, 3);
    exp_order = '{1, 2};
    chk_seen("rst_mid_grant_order", exp_order);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [NCH-1:0] s;
      logic [NCH-1:0] c;
      for (int i = 0; i < NCH; i++) begin
        s[i] = ($urandom_range(0, 7) == 0);
        c[i] = ($urandom_range(0, 9) == 0);
      end
      step(s, c, 1'(($urandom_range(0, 1))), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0),
           int'($urandom_range(0, NCH - 1)));
    end
    idle(2, 0);

    @(posedge clk);
    #2;
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/overflow_irq_ctrl.md
OVERFLOW_IRQ_CTRL -- requirements
Module: overflow_irq_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of overflow channels; legal values are 2..16.
REQ-002 Parameter CW, default 8: width of each per-channel event counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 en  input  1  grant enable; low blocks new grants only.
REQ-006 ovf_set  input  NCH  per-channel overflow pulse (S input), level-sampled each cycle.
REQ-007 ovf_clr  input  NCH  per-channel software clear (R input).
REQ-008 cnt_clr  input  1  clears all event counters.
REQ-009 irq_valid  output  1  registered; a granted channel is presented.
REQ-010 irq_id  output  clog2(NCH)  registered; index of the granted channel, valid while irq_valid=1.
REQ-011 irq_ack  input  1  consumer acknowledge of the presented channel.
REQ-012 flags  output  NCH  registered sticky overflow flags.
REQ-013 cnt_sel  input  clog2(NCH)  counter read select.
REQ-014 cnt_out  output  CW  combinational read of counter[cnt_sel].

Function
REQ-015 Each flag SHALL follow SR semantics: next flag = ovf_set | (flag & ~ovf_clr & ~ack_clr); set SHALL win over any clear in the same cycle.
REQ-016 ack_clr for channel i SHALL be 1 only in the cycle in which the FSM is in GRANT, irq_ack=1, and irq_id=i.
REQ-017 counter[i] SHALL increment by 1 on each cycle with ovf_set[i]=1 and saturate at 2^CW-1 without wrapping.
REQ-018 cnt_clr SHALL zero all counters; if ovf_set[i]=1 in the same cycle, counter[i] SHALL become 1.
REQ-019 The FSM SHALL have exactly three states: IDLE, GRANT and HOLD.
REQ-020 In IDLE with en=1 and any flag set, the FSM SHALL select the first set flag searching round-robin from ptr+1 (modulo NCH), load irq_id, and move to GRANT.
REQ-021 irq_valid SHALL be 1 exactly while in GRANT; irq_id SHALL remain stable throughout GRANT.
REQ-022 In GRANT with irq_ack=1, the FSM SHALL clear the granted flag (subject to REQ-015), load ptr with irq_id, and move to HOLD.
REQ-023 In GRANT with irq_ack=0 and ovf_clr[irq_id]=1, the grant SHALL be withdrawn: move to IDLE, ptr unchanged; if ovf_set[irq_id]=1 in that same cycle, there SHALL be no withdrawal.
REQ-024 If irq_ack=1 and ovf_clr[irq_id]=1 occur in the same cycle, this SHALL be treated as an acknowledge per REQ-022.
REQ-025 HOLD SHALL last exactly one cycle with irq_valid=0 and then return to IDLE.
REQ-026 irq_ack outside GRANT SHALL be ignored.
REQ-027 en=0 SHALL NOT abort a grant already in GRANT or HOLD.
REQ-028 Latency: ovf_set high in cycle N SHALL give flag=1 at N+1 and, from IDLE with en=1, irq_valid=1 at N+2.

Reset
REQ-029 While rst=1: flags=0, all counters=0, FSM=IDLE, irq_valid=0, irq_id=0, and ptr=NCH-1 so that channel 0 has first priority.
REQ-030 rst SHALL override all other inputs in the same cycle, including a mid-GRANT reset; irq_valid SHALL be 0 in the cycle after rst is sampled.

Verification
REQ-031 Single event: pulse ovf_set=4'b0100 for 1 cycle at N, en=1 -> flags=4'b0100 at N+1, irq_valid=1 with irq_id=2 at N+2; irq_ack -> flags=0, one HOLD cycle, IDLE.
REQ-032 Round-robin: set all four flags and ack each grant immediately -> grant order 0,1,2,3; then re-set flags 0 and 3 -> order 0,3.
REQ-033 Set beats clear: in GRANT for channel 1, drive irq_ack=1 and ovf_set[1]=1 together -> flags[1] stays 1, counter[1] increments, ch1 re-granted only after ch2/ch3 if pending.
REQ-034 Withdraw: in GRANT for channel 2 with irq_ack=0, pulse ovf_clr[2] -> irq_valid=0 next cycle, flags[2]=0, ptr unchanged.
REQ-035 Saturation: CW=8, hold ovf_set[0]=1 for 300 cycles -> cnt_out=255 with cnt_sel=0; cnt_clr with ovf_set[0]=1 -> 1.
REQ-036 Reset mid-grant: assert rst during GRANT -> next cycle irq_valid=0, flags=0, counters=0; post-reset first grant goes to the lowest-index set flag.
